// File: rtl/tron_pkg.sv
// Shared types and constants for the trail compositor: head-probe offsets,
// default background/transparent indices, FSM state encoding.
package tron_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  typedef logic [9:0] coord_t;
  typedef logic [3:0] pixel_t;

  localparam pixel_t BG_DEFAULT     = 4'h8;
  localparam pixel_t TRANSP_DEFAULT = 4'hF;

  // Offsets are 10-bit two's complement so the probe wraps mod 1024.
  localparam coord_t HEAD_OFS_X [4] = '{10'd3, 10'd3, 10'h3F2, 10'd14};
  localparam coord_t HEAD_OFS_Y [4] = '{10'h3F2, 10'd14, 10'd3, 10'd3};

  function automatic coord_t probe_x_of(coord_t hx, dir_t d);
    return hx + HEAD_OFS_X[d];
  endfunction

  function automatic coord_t probe_y_of(coord_t hy, dir_t d);
    return hy + HEAD_OFS_Y[d];
  endfunction

endpackage

// File: rtl/frame_ram_packed.sv
// Packed-pixel trail RAM: one narrow array per lane so each pixel is
// individually writable; registered read returns old data on a same-address write.
module frame_ram_packed #(
  parameter int DEPTH        = 64,
  parameter int ADDR_W       = 6,
  parameter int PIX_BITS     = 4,
  parameter int PIX_PER_WORD = 2
) (
  input  logic                             clk,
  input  logic [PIX_PER_WORD-1:0]          we,
  input  logic [ADDR_W-1:0]                waddr,
  input  logic [PIX_BITS*PIX_PER_WORD-1:0] wdata,
  input  logic [ADDR_W-1:0]                raddr,
  output logic [PIX_BITS*PIX_PER_WORD-1:0] rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
      logic [PIX_BITS-1:0] mem [DEPTH];
      logic [PIX_BITS-1:0] rd_reg;

      always_ff @(posedge clk) begin
        if (we[gi]) mem[waddr] <= wdata[gi*PIX_BITS +: PIX_BITS];
        rd_reg <= mem[raddr];
      end

      assign rdata[gi*PIX_BITS +: PIX_BITS] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/trail_compositor.sv
// N-player trail compositor: trail RAM with clear sweep, 2-stage sprite merge,
// per-frame head-probe collision. TRAIL_HEAD_MARK_EN paints each probe pixel in player colour.
module trail_compositor
  import tron_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int PIX_BITS     = 4,
  parameter int PIX_PER_WORD = 2,
  parameter logic [PIX_BITS-1:0] BG_COLOR = PIX_BITS'(BG_DEFAULT),
  parameter logic [PIX_BITS-1:0] TRANSP   = PIX_BITS'(TRANSP_DEFAULT)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_start,
  input  logic                        pix_valid,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic [PIX_BITS-1:0]         sprite_idx,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [9:0]                  wr_x,
  input  logic [9:0]                  wr_y,
  input  logic [PIX_BITS-1:0]         wr_color,
  input  logic                        clear_req,
  output logic                        clear_busy,
  input  logic [NUM_PLAYERS-1:0][9:0] head_x,
  input  logic [NUM_PLAYERS-1:0][9:0] head_y,
  input  logic [NUM_PLAYERS-1:0][1:0] head_dir,
  output logic [PIX_BITS-1:0]         color_enum,
  output logic                        out_valid,
  output logic [NUM_PLAYERS-1:0]      collide
);

  localparam int WORD_BITS     = PIX_BITS * PIX_PER_WORD;
  localparam int WORDS_PER_ROW = H_RES / PIX_PER_WORD;
  localparam int DEPTH         = WORDS_PER_ROW * V_RES;
  localparam int ADDR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LANE_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [9:0] H_LIM = 10'(H_RES);
  localparam logic [9:0] V_LIM = 10'(V_RES);
  localparam logic [9:0] PPW   = 10'(PIX_PER_WORD);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  function automatic logic [ADDR_W-1:0] word_addr(logic [9:0] x, logic [9:0] y);
    return ADDR_W'(y) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(x / PPW);
  endfunction

  function automatic logic [LANE_W-1:0] lane_of(logic [9:0] x);
    return LANE_W'(x % PPW);
  endfunction

  clr_state_t              state_reg, state_next;
  logic [ADDR_W-1:0]       clr_cnt_reg;
  logic [PIX_PER_WORD-1:0] ram_we;
  logic [ADDR_W-1:0]       ram_waddr;
  logic [WORD_BITS-1:0]    ram_wdata;
  logic [WORD_BITS-1:0]    ram_rdata;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg   <= ST_IDLE;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= (state_reg == ST_CLEAR) ? clr_cnt_reg + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (clear_req) state_next = ST_CLEAR;
      ST_CLEAR: if (clr_cnt_reg == LAST_WORD) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Off-screen writes are handshaken but never reach the RAM.
  always_comb begin
    wr_ready   = 1'b0;
    clear_busy = 1'b0;
    ram_we     = '0;
    ram_waddr  = word_addr(wr_x, wr_y);
    ram_wdata  = {PIX_PER_WORD{wr_color}};
    case (state_reg)
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid && wr_x < H_LIM && wr_y < V_LIM)
          ram_we = PIX_PER_WORD'(1) << lane_of(wr_x);
      end
      ST_CLEAR: begin
        clear_busy = 1'b1;
        ram_we     = '1;
        ram_waddr  = clr_cnt_reg;
        ram_wdata  = {PIX_PER_WORD{BG_COLOR}};
      end
      default: ;
    endcase
  end

  frame_ram_packed #(
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .PIX_BITS     (PIX_BITS),
    .PIX_PER_WORD (PIX_PER_WORD)
  ) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (word_addr(DrawX, DrawY)),
    .rdata (ram_rdata)
  );

  logic                v1_reg;
  logic [LANE_W-1:0]   lane1_reg;
  coord_t              x1_reg, y1_reg;
  logic [PIX_BITS-1:0] spr1_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v1_reg    <= 1'b0;
      lane1_reg <= '0;
      x1_reg    <= '0;
      y1_reg    <= '0;
      spr1_reg  <= TRANSP;
    end else begin
      v1_reg    <= pix_valid;
      lane1_reg <= lane_of(DrawX);
      x1_reg    <= DrawX;
      y1_reg    <= DrawY;
      spr1_reg  <= sprite_idx;
    end
  end

  logic [PIX_BITS-1:0] lane_pix [PIX_PER_WORD];
  logic [PIX_BITS-1:0] trail_pix;
  coord_t              probe_x [NUM_PLAYERS];
  coord_t              probe_y [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] at_probe, hit_now;

  genvar gi;
  generate
    for (gi = 0; gi < PIX_PER_WORD; gi++) begin : g_unpack
      assign lane_pix[gi] = ram_rdata[gi*PIX_BITS +: PIX_BITS];
    end
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_probe
      assign probe_x[gi]  = probe_x_of(head_x[gi], dir_t'(head_dir[gi]));
      assign probe_y[gi]  = probe_y_of(head_y[gi], dir_t'(head_dir[gi]));
      assign at_probe[gi] = v1_reg && x1_reg == probe_x[gi] && y1_reg == probe_y[gi]
                            && probe_x[gi] < H_LIM && probe_y[gi] < V_LIM;
      assign hit_now[gi]  = at_probe[gi] && trail_pix != BG_COLOR;
    end
  endgenerate

  assign trail_pix = lane_pix[lane1_reg];

  logic [PIX_BITS-1:0] color_next;

  always_comb begin
    color_next = trail_pix;
`ifdef TRAIL_HEAD_MARK_EN
    for (int p = NUM_PLAYERS - 1; p >= 0; p--)
      if (at_probe[p]) color_next = PIX_BITS'(p + 1);
`endif
    if (spr1_reg != TRANSP) color_next = spr1_reg;
  end

  logic                   out_valid_reg;
  logic [PIX_BITS-1:0]    color_reg;
  logic [NUM_PLAYERS-1:0] hit_sticky_reg, collide_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid_reg  <= 1'b0;
      color_reg      <= BG_COLOR;
      hit_sticky_reg <= '0;
      collide_reg    <= '0;
    end else begin
      out_valid_reg <= v1_reg;
      if (v1_reg) color_reg <= color_next;
      // A hit landing on the frame_start cycle still counts for the ending frame.
      if (frame_start) begin
        collide_reg    <= hit_sticky_reg | hit_now;
        hit_sticky_reg <= '0;
      end else begin
        hit_sticky_reg <= hit_sticky_reg | hit_now;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign color_enum = color_reg;
  assign collide    = collide_reg;

endmodule

// File: tb/tb_trail_compositor.sv
// Directed bench for trail_compositor at H_RES=16, V_RES=8, two players;
// expected pixels come from a small frame model kept by the bench.
module tb_trail_compositor;

  localparam int NP = 2;
  localparam int HR = 16;
  localparam int VR = 8;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic            frame_start, pix_valid, wr_valid, clear_req;
  logic [9:0]      DrawX, DrawY, wr_x, wr_y;
  logic [3:0]      sprite_idx, wr_color;
  logic            wr_ready, clear_busy, out_valid;
  logic [3:0]      color_enum;
  logic [NP-1:0]   collide;
  logic [NP-1:0][9:0] head_x, head_y;
  logic [NP-1:0][1:0] head_dir;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_pix [VR][HR];

  trail_compositor #(
    .NUM_PLAYERS (NP),
    .H_RES       (HR),
    .V_RES       (VR)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .sprite_idx  (sprite_idx),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .clear_req   (clear_req),
    .clear_busy  (clear_busy),
    .head_x      (head_x),
    .head_y      (head_y),
    .head_dir    (head_dir),
    .color_enum  (color_enum),
    .out_valid   (out_valid),
    .collide     (collide)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int ofs_x(logic [1:0] d);
    if (d == 2'b10) return -14;
    if (d == 2'b11) return 14;
    return 3;
  endfunction

  function automatic int ofs_y(logic [1:0] d);
    if (d == 2'b00) return -14;
    if (d == 2'b01) return 14;
    return 3;
  endfunction

  function automatic logic [3:0] model_color(int x, int y, logic [3:0] spr);
    if (spr != 4'hF) return spr;
`ifdef TRAIL_HEAD_MARK_EN
    for (int p = 0; p < NP; p++) begin
      int px, py;
      px = (int'(head_x[p]) + ofs_x(head_dir[p])) & 1023;
      py = (int'(head_y[p]) + ofs_y(head_dir[p])) & 1023;
      if (px == x && py == y) return 4'(p + 1);
    end
`endif
    return exp_pix[y][x];
  endfunction

  task automatic read_pixel(input int x, input int y, input logic [3:0] spr,
                            output logic v, output logic [3:0] c);
    DrawX = 10'(x); DrawY = 10'(y); sprite_idx = spr; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0; sprite_idx = 4'hF;
    tick();
    v = out_valid; c = color_enum;
  endtask

  task automatic do_write(input int x, input int y, input logic [3:0] col);
    wr_valid = 1'b1; wr_x = 10'(x); wr_y = 10'(y); wr_color = col;
    tick();
    wr_valid = 1'b0;
    if (x < HR && y < VR) exp_pix[y][x] = col;
    $display("write (%0d,%0d)=%h", x, y, col);
  endtask

  task automatic scan_frame(output int errs, output int fx, output int fy, output logic [3:0] fc);
    logic v; logic [3:0] c;
    errs = 0; fx = -1; fy = -1; fc = 4'h0;
    for (int y = 0; y < VR; y++)
      for (int x = 0; x < HR; x++) begin
        read_pixel(x, y, 4'hF, v, c);
        if (v !== 1'b1 || c !== model_color(x, y, 4'hF)) begin
          if (errs == 0) begin fx = x; fy = y; fc = c; end
          errs++;
        end
      end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    frame_start = 0; pix_valid = 0; wr_valid = 0; clear_req = 0;
    DrawX = 0; DrawY = 0; sprite_idx = 4'hF; wr_x = 0; wr_y = 0; wr_color = 0;
    head_x = '0; head_y = '0; head_dir = {2'b01, 2'b01};
    #2 Reset = 1'b1;
    tick(); tick();
    total++; if (color_enum !== 4'h8) begin bad++; $display("FAIL reset_color got=%h want=8", color_enum); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (collide !== 2'b00) begin bad++; $display("FAIL reset_collide got=%b want=00", collide); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL reset_clear_busy got=%b want=0", clear_busy); end
    Reset = 1'b0;
    tick();
    $display("reset released");
  endtask

  task automatic test_clear();
    int cnt, wr_bad, errs, fx, fy;
    logic [3:0] fc;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cnt = 0; wr_bad = 0;
    while (clear_busy === 1'b1 && cnt < 200) begin
      if (wr_ready !== 1'b0) wr_bad++;
      cnt++;
      tick();
    end
    total++; if (cnt !== 64) begin bad++; $display("FAIL clear_len got=%0d want=64", cnt); end
    total++; if (wr_bad !== 0) begin bad++; $display("FAIL clear_wr_ready got=%0d cycles high want=0", wr_bad); end
    for (int y = 0; y < VR; y++) for (int x = 0; x < HR; x++) exp_pix[y][x] = 4'h8;
    scan_frame(errs, fx, fy, fc);
    total++; if (errs !== 0) begin bad++; $display("FAIL clear_scan %0d bad pixels, first (%0d,%0d) got=%h want=8", errs, fx, fy, fc); end
    $display("clear sweep %0d cycles", cnt);
  endtask

  task automatic test_write();
    logic v; logic [3:0] c;
    do_write(3, 2, 4'h1);
    do_write(2, 2, 4'h5);
    do_write(16, 2, 4'h7);
    do_write(3, 8, 4'h7);
    read_pixel(3, 2, 4'hF, v, c);
    total++; if (v !== 1'b1 || c !== 4'h1) begin bad++; $display("FAIL write_lane1 got v=%b c=%h want v=1 c=1", v, c); end
    read_pixel(2, 2, 4'hF, v, c);
    total++; if (v !== 1'b1 || c !== 4'h5) begin bad++; $display("FAIL write_lane0 got v=%b c=%h want v=1 c=5", v, c); end
    read_pixel(0, 3, 4'hF, v, c);
    total++; if (c !== 4'h8) begin bad++; $display("FAIL write_drop_x got=%h want=8", c); end
    read_pixel(3, 0, 4'hF, v, c);
    total++; if (c !== 4'h8) begin bad++; $display("FAIL write_drop_y got=%h want=8", c); end
  endtask

  task automatic test_sprite();
    logic v; logic [3:0] c;
    read_pixel(3, 2, 4'h2, v, c);
    total++; if (c !== 4'h2) begin bad++; $display("FAIL sprite_over_trail got=%h want=2", c); end
    read_pixel(3, 2, 4'hF, v, c);
    total++; if (c !== 4'h1) begin bad++; $display("FAIL sprite_transp got=%h want=1", c); end
    read_pixel(5, 5, 4'h0, v, c);
    total++; if (c !== 4'h0) begin bad++; $display("FAIL sprite_over_bg got=%h want=0", c); end
    $display("sprite merge checked");
  endtask

  task automatic test_back_to_back();
    DrawX = 2; DrawY = 2; sprite_idx = 4'hF; pix_valid = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_latency got=%b want=0", out_valid); end
    DrawX = 3; DrawY = 2; sprite_idx = 4'hF;
    tick();
    total++; if (out_valid !== 1'b1 || color_enum !== 4'h5) begin bad++; $display("FAIL b2b_p0 got v=%b c=%h want v=1 c=5", out_valid, color_enum); end
    DrawX = 3; DrawY = 2; sprite_idx = 4'h2;
    tick();
    total++; if (out_valid !== 1'b1 || color_enum !== 4'h1) begin bad++; $display("FAIL b2b_p1 got v=%b c=%h want v=1 c=1", out_valid, color_enum); end
    pix_valid = 1'b0; sprite_idx = 4'hF;
    tick();
    total++; if (out_valid !== 1'b1 || color_enum !== 4'h2) begin bad++; $display("FAIL b2b_p2 got v=%b c=%h want v=1 c=2", out_valid, color_enum); end
    tick();
    total++; if (out_valid !== 1'b0 || color_enum !== 4'h2) begin bad++; $display("FAIL b2b_hold got v=%b c=%h want v=0 c=2", out_valid, color_enum); end
    $display("back-to-back reads checked");
  endtask

  task automatic test_read_before_write();
    logic v; logic [3:0] c;
    DrawX = 3; DrawY = 2; sprite_idx = 4'hF; pix_valid = 1'b1;
    wr_valid = 1'b1; wr_x = 3; wr_y = 2; wr_color = 4'h9;
    tick();
    pix_valid = 1'b0; wr_valid = 1'b0;
    exp_pix[2][3] = 4'h9;
    tick();
    total++; if (color_enum !== 4'h1) begin bad++; $display("FAIL rbw_old got=%h want=1", color_enum); end
    read_pixel(3, 2, 4'hF, v, c);
    total++; if (c !== 4'h9) begin bad++; $display("FAIL rbw_new got=%h want=9", c); end
    $display("read-before-write checked");
  endtask

  task automatic test_collision();
    int errs, fx, fy;
    logic [3:0] fc;
    head_x[0] = 10'd0; head_y[0] = 10'd16; head_dir[0] = 2'b00;
    pulse_frame();
    total++; if (collide !== 2'b00) begin bad++; $display("FAIL coll_initial got=%b want=00", collide); end
    scan_frame(errs, fx, fy, fc);
    total++; if (errs !== 0) begin bad++; $display("FAIL coll_scan0 %0d bad pixels, first (%0d,%0d) got=%h", errs, fx, fy, fc); end
    total++; if (collide !== 2'b00) begin bad++; $display("FAIL coll_midframe got=%b want=00", collide); end
    pulse_frame();
    total++; if (collide !== 2'b01) begin bad++; $display("FAIL coll_p0 got=%b want=01", collide); end
    $display("frame 1 collide=%b", collide);
    // P0 now probes background; P1 wraps from (1012,1023) onto (2,2)
    head_y[0] = 10'd19;
    head_x[1] = 10'd1012; head_y[1] = 10'd1023; head_dir[1] = 2'b11;
    scan_frame(errs, fx, fy, fc);
    total++; if (errs !== 0) begin bad++; $display("FAIL coll_scan1 %0d bad pixels, first (%0d,%0d) got=%h", errs, fx, fy, fc); end
    pulse_frame();
    total++; if (collide !== 2'b10) begin bad++; $display("FAIL coll_p1_wrap got=%b want=10", collide); end
    $display("frame 2 collide=%b", collide);
    head_x[1] = 10'd0; head_y[1] = 10'd0; head_dir[1] = 2'b01;
    scan_frame(errs, fx, fy, fc);
    pulse_frame();
    total++; if (collide !== 2'b00) begin bad++; $display("FAIL coll_none got=%b want=00", collide); end
    $display("frame 3 collide=%b", collide);
  endtask

  task automatic test_clear_write_hold();
    int cnt, wr_bad, errs, fx, fy;
    logic [3:0] fc;
    head_x[0] = 10'd0; head_y[0] = 10'd0; head_dir[0] = 2'b01;
    clear_req = 1'b1;
    wr_valid = 1'b1; wr_x = 0; wr_y = 0; wr_color = 4'h6;
    tick();
    clear_req = 1'b0;
    cnt = 0; wr_bad = 0;
    while (clear_busy === 1'b1 && cnt < 200) begin
      if (wr_ready !== 1'b0) wr_bad++;
      cnt++;
      tick();
    end
    total++; if (wr_bad !== 0 || cnt !== 64) begin bad++; $display("FAIL hold_during_clear got %0d ready cycles, len=%0d want 0,64", wr_bad, cnt); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL hold_first_ready got=%b want=1", wr_ready); end
    wr_x = 5; wr_y = 1; wr_color = 4'h3;
    tick();
    wr_valid = 1'b0;
    for (int y = 0; y < VR; y++) for (int x = 0; x < HR; x++) exp_pix[y][x] = 4'h8;
    exp_pix[1][5] = 4'h3;
    scan_frame(errs, fx, fy, fc);
    total++; if (errs !== 0) begin bad++; $display("FAIL hold_scan %0d bad pixels, first (%0d,%0d) got=%h", errs, fx, fy, fc); end
    $display("write held across clear, accepted after %0d busy cycles", cnt);
  endtask

  task automatic test_reset_mid_clear();
    logic v; logic [3:0] c;
    do_write(3, 2, 4'h4);
    head_x[0] = 10'd0; head_y[0] = 10'd16; head_dir[0] = 2'b00;
    read_pixel(3, 2, 4'h2, v, c);
    total++; if (c !== 4'h2) begin bad++; $display("FAIL rst_pre_sprite got=%h want=2", c); end
    pulse_frame();
    total++; if (collide !== 2'b01) begin bad++; $display("FAIL rst_pre_collide got=%b want=01", collide); end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    total++; if (clear_busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%b want=1", clear_busy); end
    Reset = 1'b1;
    #1;
    total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", clear_busy); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_wr_ready got=%b want=1", wr_ready); end
    total++; if (collide !== 2'b00) begin bad++; $display("FAIL rst_mid_collide got=%b want=00", collide); end
    tick();
    Reset = 1'b0;
    tick(); tick();
    total++; if (clear_busy !== 1'b0 || wr_ready !== 1'b1) begin bad++; $display("FAIL rst_post_idle got busy=%b ready=%b want 0,1", clear_busy, wr_ready); end
    $display("reset during clear checked");
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write();
    test_sprite();
    test_back_to_back();
    test_read_before_write();
    test_collision();
    test_clear_write_hold();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
